spi_master: RTL and testbench

Transaction engine that drives the serial side of the `ichip_1` SPI slave. It accepts a single-cycle host request (register read or write), generates `sck`, `mosi` and the active-high chip `enable`, and shifts out a command byte followed by a data byte. On reads it captures the byte returned on `miso`. It sits directly upstream of the slave and is clocked from the same internal `clk`.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_gen.sv | 39 +++
 rtl/spi_master.sv | 94 +++++++++
 tb/tb_spi_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transaction engine.
package spi_pkg;
    localparam int SPI_ADDR_W = 4;
    localparam int SPI_BYTE_W = 8;
    localparam int SPI_RD_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        CMD,
        GAP,
        DATA,
        TRAIL,
        DONE
    } spi_state_t;

    // Command byte layout: read flag at SPI_RD_BIT, address in the low nibble.
    function automatic logic [SPI_BYTE_W-1:0] spi_cmd_byte(input logic rd,
                                                           input logic [SPI_ADDR_W-1:0] addr);
        logic [SPI_BYTE_W-1:0] b;
        b                 = '0;
        b[SPI_ADDR_W-1:0] = addr;
        b[SPI_RD_BIT]     = rd;
        return b;
    endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// Mode-0 sck generator: CLK_DIV cycles low then CLK_DIV high while run is set.
// Latency: first rise CLK_DIV cycles after run rises; no backpressure, sck parks low when run drops.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_div;
    logic       r_sck;
    logic       w_edge;

    assign w_edge = run && (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (!run) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (w_edge) begin
            r_div <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    assign sck      = r_sck;
    assign rise_stb = w_edge & ~r_sck;
    assign fall_stb = w_edge & r_sck;
endmodule

// File: rtl/spi_master.sv
// SPI master: one start strobe runs command byte + data byte to the slave, LSB first, mode 0.
// Latency: done 34*CLK_DIV+GAP_CYCLES cycles after accept; start is ignored while busy (no queueing).
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  master_reset,
    input  logic                  start,
    input  logic                  rd,
    input  logic [SPI_ADDR_W-1:0] addr,
    input  logic [SPI_BYTE_W-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_BYTE_W-1:0] rdata,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  enable
);
    localparam logic [7:0] CD_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    spi_state_t            r_state, w_next;
    logic [7:0]            r_cnt;
    logic [2:0]            r_bit;
    logic [SPI_BYTE_W-1:0] r_tx, r_rx, r_data, r_rdata;
    logic                  r_rd;
    logic                  w_run, w_rise, w_fall, w_byte_end, w_timed, w_accept;

    assign w_run      = (r_state == CMD) || (r_state == DATA);
    assign w_timed    = (r_state == LEAD) || (r_state == GAP) || (r_state == TRAIL);
    assign w_accept   = (r_state == IDLE) && start;
    assign w_byte_end = w_fall && (r_bit == 3'd7);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (master_reset),
        .run      (w_run),
        .sck      (sck),
        .rise_stb (w_rise),
        .fall_stb (w_fall)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = LEAD;
            LEAD:  if (r_cnt == CD_LAST) w_next = CMD;
            CMD:   if (w_byte_end) w_next = (GAP_CYCLES == 0) ? DATA : GAP;
            GAP:   if (r_cnt == GAP_LAST) w_next = DATA;
            DATA:  if (w_byte_end) w_next = TRAIL;
            TRAIL: if (r_cnt == CD_LAST) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_data  <= '0;
            r_rd    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_timed && (w_next == r_state)) ? r_cnt + 8'd1 : '0;
            if (w_fall) r_bit <= r_bit + 3'd1;
            // mosi only moves on sck falls; the data byte replaces the command at its last fall
            if (w_accept) begin
                r_rd   <= rd;
                r_data <= rd ? '0 : wdata;
                r_tx   <= spi_cmd_byte(rd, addr);
            end else if (w_fall) begin
                if (w_byte_end) r_tx <= (r_state == CMD) ? r_data : '0;
                else            r_tx <= {1'b0, r_tx[SPI_BYTE_W-1:1]};
            end
            if (w_rise && (r_state == DATA)) r_rx <= {miso, r_rx[SPI_BYTE_W-1:1]};
            if ((r_state == TRAIL) && (w_next == DONE) && r_rd) r_rdata <= r_rx;
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign enable = busy && !done;
    assign mosi   = r_tx[0];
    assign rdata  = r_rdata;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default instance plus a CLK_DIV=2 / GAP_CYCLES=0 instance.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       master_reset = 1'b1;
    logic       start = 1'b0, start2 = 1'b0, rd = 1'b0;
    logic       miso = 1'b0, miso2 = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, sck, mosi, enable;
    logic       busy2, done2, sck2, mosi2, enable2;
    logic [7:0] rdata, rdata2;

    int         n_cmp = 0, n_err = 0, cyc = 0, fall_n = 0;
    logic       prev_sck = 1'b0, prev_sck2 = 1'b0;
    logic [7:0] slave_byte = '0;
    logic       q_obs[$];
    int         q_rcyc[$];
    int         q2_rise[$];
    logic [7:0] q_exp[$];
    logic [7:0] q_exp_rd[$];

    spi_master #(.CLK_DIV(4), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .master_reset(master_reset), .start(start), .rd(rd), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .sck(sck), .mosi(mosi),
        .miso(miso), .enable(enable)
    );

    spi_master #(.CLK_DIV(2), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .master_reset(master_reset), .start(start2), .rd(rd), .addr(addr),
        .wdata(wdata), .busy(busy2), .done(done2), .rdata(rdata2), .sck(sck2), .mosi(mosi2),
        .miso(miso2), .enable(enable2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and slave model: record mosi at each sck rise, drive miso after each fall of the data phase.
    always @(negedge clk) begin
        if (sck && !prev_sck) begin
            q_obs.push_back(mosi);
            q_rcyc.push_back(cyc);
        end
        if (!enable) fall_n <= 0;
        else if (!sck && prev_sck) begin
            fall_n <= fall_n + 1;
            if (fall_n >= 7 && fall_n <= 14) miso <= slave_byte[3'(fall_n - 7)];
        end
        if (sck2 && !prev_sck2) q2_rise.push_back(cyc);
        prev_sck  <= sck;
        prev_sck2 <= sck2;
    end

    function automatic logic [7:0] get_byte(input int b, input int k);
        logic [7:0] v;
        v = 'x;
        for (int i = 0; i < 8; i++)
            if (b + 8 * k + i < q_obs.size()) v[i] = q_obs[b + 8 * k + i];
        return v;
    endfunction

    // Drives one request on u_dut (called at a negedge) and collects what happened.
    task automatic do_txn(input logic t_rd, input logic [3:0] t_addr, input logic [7:0] t_wdata,
                          input logic [7:0] t_slave, input bit t_poke, input int t_post,
                          output int o_e, output int o_done, output int o_base, output int o_en_low,
                          output int o_done_n, output int o_busy_after, output bit o_rd_early,
                          output logic [7:0] o_rdata);
        logic [7:0] rd0;
        o_base = q_obs.size(); slave_byte = t_slave; rd0 = rdata;
        o_en_low = 0; o_done_n = 0; o_busy_after = 0; o_rd_early = 0; o_done = -1; o_rdata = 'x;
        rd = t_rd; addr = t_addr; wdata = t_wdata; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_e = cyc; start = 1'b0;
        rd = 1'($urandom); addr = 4'($urandom); wdata = 8'($urandom);
        for (int i = 0; i < 600 && o_done < 0; i++) begin
            if (done) begin
                o_done = cyc; o_done_n++; o_rdata = rdata;
            end else begin
                if (!enable) o_en_low++;
                if (rdata !== rd0) o_rd_early = 1'b1;
            end
            start = t_poke && (cyc == o_e + 10 || done);
            if (o_done < 0) @(negedge clk);
        end
        for (int i = 0; i < t_post; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) o_done_n++;
            if (busy) o_busy_after++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        master_reset = 1'b1;
        #1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, sck, mosi, enable} !== 5'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 00000", {busy, done, sck, mosi, enable}); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if ({busy2, done2, sck2, mosi2, enable2} !== 5'b0) begin n_err++; $display("FAIL reset_ctl2: got %b want 00000", {busy2, done2, sck2, mosi2, enable2}); end
        n_cmp++; if (rdata2 !== 8'h00) begin n_err++; $display("FAIL reset_rdata2: got %h want 00", rdata2); end
        master_reset = 1'b0;
    endtask

    task automatic test_write_a5();
        int e, d, b, enl, dn, ba; bit early; logic [7:0] rdd, x;
        q_exp.push_back(8'h03); q_exp.push_back(8'hA5); q_exp_rd.push_back(8'h00);
        do_txn(1'b0, 4'd3, 8'hA5, 8'h00, 1'b0, 2, e, d, b, enl, dn, ba, early, rdd);
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 0) !== x) begin n_err++; $display("FAIL wr_cmd: got %h want %h", get_byte(b, 0), x); end
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 1) !== x) begin n_err++; $display("FAIL wr_data: got %h want %h", get_byte(b, 1), x); end
        x = q_exp_rd.pop_front();
        n_cmp++; if (rdd !== x) begin n_err++; $display("FAIL wr_rdata: got %h want %h", rdd, x); end
        n_cmp++; if (d !== e + 138) begin n_err++; $display("FAIL wr_done_time: got %0d want %0d", d - e, 138); end
        n_cmp++; if (q_rcyc[b] !== e + 8) begin n_err++; $display("FAIL wr_first_rise: got %0d want %0d", q_rcyc[b] - e, 8); end
        n_cmp++; if (enl !== 0) begin n_err++; $display("FAIL wr_enable_low: got %0d want 0", enl); end
    endtask

    task automatic test_read_5a();
        int e, d, b, enl, dn, ba; bit early; logic [7:0] rdd, x;
        q_exp.push_back(8'h13); q_exp.push_back(8'h00); q_exp_rd.push_back(8'h5A);
        do_txn(1'b1, 4'd3, 8'hC3, 8'h5A, 1'b0, 2, e, d, b, enl, dn, ba, early, rdd);
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 0) !== x) begin n_err++; $display("FAIL rd_cmd: got %h want %h", get_byte(b, 0), x); end
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 1) !== x) begin n_err++; $display("FAIL rd_data_byte: got %h want %h", get_byte(b, 1), x); end
        x = q_exp_rd.pop_front();
        n_cmp++; if (rdd !== x) begin n_err++; $display("FAIL rd_rdata: got %h want %h", rdd, x); end
        n_cmp++; if (d !== e + 138) begin n_err++; $display("FAIL rd_done_time: got %0d want %0d", d - e, 138); end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL rd_rdata_early: got %b want 0", early); end
    endtask

    task automatic test_ignore_start();
        int e, d, b, enl, dn, ba; bit early; logic [7:0] rdd, x;
        q_exp.push_back(8'h09); q_exp.push_back(8'h77); q_exp_rd.push_back(8'h5A);
        do_txn(1'b0, 4'd9, 8'h77, 8'h00, 1'b1, 40, e, d, b, enl, dn, ba, early, rdd);
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 0) !== x) begin n_err++; $display("FAIL ign_cmd: got %h want %h", get_byte(b, 0), x); end
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 1) !== x) begin n_err++; $display("FAIL ign_data: got %h want %h", get_byte(b, 1), x); end
        x = q_exp_rd.pop_front();
        n_cmp++; if (rdata !== x) begin n_err++; $display("FAIL ign_rdata_held: got %h want %h", rdata, x); end
        n_cmp++; if (q_obs.size() - b !== 16) begin n_err++; $display("FAIL ign_rises: got %0d want 16", q_obs.size() - b); end
        n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL ign_done_pulses: got %0d want 1", dn); end
        n_cmp++; if (ba !== 0) begin n_err++; $display("FAIL ign_busy_after: got %0d want 0", ba); end
    endtask

    task automatic test_reset_mid();
        int e, d, b, enl, dn, ba; bit early; logic [7:0] rdd, x;
        b = q_obs.size();
        rd = 1'b0; addr = 4'd5; wdata = 8'hE7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && q_obs.size() - b < 3; i++) @(negedge clk);
        n_cmp++; if (q_obs.size() - b !== 3) begin n_err++; $display("FAIL rst_mid_rises: got %0d want 3", q_obs.size() - b); end
        #2 master_reset = 1'b1;
        #1;
        n_cmp++; if ({sck, enable, busy} !== 3'b000) begin n_err++; $display("FAIL rst_mid_async: got %b want 000", {sck, enable, busy}); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rst_mid_rdata: got %h want 00", rdata); end
        @(negedge clk);
        master_reset = 1'b0;
        q_exp.push_back(8'h00); q_exp.push_back(8'h3C);
        do_txn(1'b0, 4'd0, 8'h3C, 8'h00, 1'b0, 2, e, d, b, enl, dn, ba, early, rdd);
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 0) !== x) begin n_err++; $display("FAIL rst_wr_cmd: got %h want %h", get_byte(b, 0), x); end
        x = q_exp.pop_front();
        n_cmp++; if (get_byte(b, 1) !== x) begin n_err++; $display("FAIL rst_wr_data: got %h want %h", get_byte(b, 1), x); end
        n_cmp++; if (d !== e + 138) begin n_err++; $display("FAIL rst_wr_done_time: got %0d want %0d", d - e, 138); end
    endtask

    task automatic test_back_to_back();
        int e, d, b, enl, dn, ba; bit early; logic [7:0] rdd, x;
        logic [7:0] ret [2];
        ret[0] = 8'hFF; ret[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            q_exp.push_back(8'h1F); q_exp.push_back(8'h00); q_exp_rd.push_back(ret[k]);
            do_txn(1'b1, 4'd15, 8'h00, ret[k], 1'b0, 1, e, d, b, enl, dn, ba, early, rdd);
            x = q_exp.pop_front();
            n_cmp++; if (get_byte(b, 0) !== x) begin n_err++; $display("FAIL b2b%0d_cmd: got %h want %h", k, get_byte(b, 0), x); end
            x = q_exp.pop_front();
            n_cmp++; if (get_byte(b, 1) !== x) begin n_err++; $display("FAIL b2b%0d_data: got %h want %h", k, get_byte(b, 1), x); end
            x = q_exp_rd.pop_front();
            n_cmp++; if (rdd !== x) begin n_err++; $display("FAIL b2b%0d_rdata: got %h want %h", k, rdd, x); end
            n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL b2b%0d_rdata_early: got %b want 0", k, early); end
            n_cmp++; if (d !== e + 138) begin n_err++; $display("FAIL b2b%0d_done_time: got %0d want %0d", k, d - e, 138); end
        end
    endtask

    task automatic test_fast_gap0();
        int e, d, b, n, bad, fr, gap;
        b = q2_rise.size(); d = -1; bad = 0;
        rd = 1'b0; addr = 4'h6; wdata = 8'h81; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e = cyc; start2 = 1'b0;
        for (int i = 0; i < 300 && d < 0; i++) begin
            if (done2) d = cyc;
            else @(negedge clk);
        end
        @(negedge clk);
        n   = q2_rise.size() - b;
        fr  = (n > 0) ? q2_rise[b] - e : -1;
        gap = (n >= 9) ? q2_rise[b + 8] - q2_rise[b + 7] : -1;
        for (int i = 1; i < n; i++) if (q2_rise[b + i] - q2_rise[b + i - 1] != 4) bad++;
        n_cmp++; if (d !== e + 68) begin n_err++; $display("FAIL fast_done_time: got %0d want %0d", d - e, 68); end
        n_cmp++; if (n !== 16) begin n_err++; $display("FAIL fast_rises: got %0d want 16", n); end
        n_cmp++; if (fr !== 4) begin n_err++; $display("FAIL fast_first_rise: got %0d want 4", fr); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fast_period: got %0d bad periods want 0", bad); end
        n_cmp++; if (gap !== 4) begin n_err++; $display("FAIL fast_byte_gap: got %0d want 4", gap); end
    endtask

    initial begin
        test_reset();
        test_write_a5();
        test_read_5a();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_fast_gap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
